// File: rtl/serial_alu.sv
// Bit-serial ALU: add/AND/NOR/XOR on WIDTH-bit operands, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start, busy=0 done=0
// RUN   | shifting one operand bit per cycle through the slice, busy=1
// DONE  | one-cycle result pulse, done=1, start accepted here too
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       aluctr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             e
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa, sb;
  logic [1:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic bit_a, bit_b, res_bit, cout, last_bit;

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (last_bit) state_nxt = DONE;
      default: state_nxt = start ? RUN : IDLE;
    endcase
  end

  // Single 1-bit slice shared by every bit position.
  always_comb begin
    bit_a   = sa[0];
    bit_b   = sb[0];
    res_bit = 1'b0;
    cout    = 1'b0;
    case (op)
      OP_ADD: begin
        res_bit = bit_a ^ bit_b ^ carry;
        cout    = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
      end
      OP_AND:  res_bit = bit_a & bit_b;
      OP_NOR:  res_bit = ~(bit_a | bit_b);
      default: res_bit = bit_a ^ bit_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      op    <= OP_ADD;
      carry <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      e     <= 1'b0;
    end else if (state == RUN) begin
      d     <= {res_bit, d[WIDTH-1:1]};
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      carry <= cout;
      cnt   <= cnt + CW'(1);
      if (last_bit) e <= (op == OP_ADD) & cout;
    end else if (start) begin
      sa    <= a;
      sb    <= b;
      op    <= aluctr;
      carry <= (aluctr == OP_ADD) & cin;
      cnt   <= '0;
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  // On the MSB step, carry holds the carry into the sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf <= 1'b0;
    else if (state == RUN && last_bit) ovf <= (op == OP_ADD) & (carry ^ cout);
  end
`endif

endmodule

// File: doc/serial_alu.md
# serial_alu

Parametrised bit-serial ALU that computes add / AND / NOR / XOR on WIDTH-bit operands one bit per clock, LSB first, reusing a single 1-bit slice datapath. It sits between a register-file style operand source and a result sink. A start/busy/done handshake sequences it, trading latency for a single full-adder slice.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- cin  input  1  carry-in for add; sampled only on the accepting edge.
- aluctr  input  2  operation select: 00 add, 01 AND, 10 NOR, 11 XOR; sampled only on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; d/e are valid in this cycle.
- d  output  WIDTH  result.
- e  output  1  carry-out for add; 0 for all other operations.
- ovf  output  1  signed overflow for add. Present only with SERIAL_ALU_OVF_EN.

## Operation
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- IDLE or DONE, with start=1 at an edge:
  - Latch a, b, aluctr into shift/opcode registers.
  - Load the carry flop with cin when aluctr=00, else with 0.
  - Clear the bit counter to 0 and go to RUN.
- IDLE or DONE, with start=0: go to IDLE (a DONE state lasts exactly one cycle).
- RUN, each edge:
  - Compute bit i from the LSBs of the A/B shift registers.
  - Add: sum = a^b^carry, carry' = majority(a,b,carry). AND: a&b. NOR: ~(a|b). XOR: a^b.
  - Shift the result bit into the MSB of d (d shifts right).
  - Shift the A/B registers right.
  - Increment the counter. When the counter equals WIDTH-1, go to DONE.
- On the edge leaving RUN:
  - e is loaded with the final carry for add, or with 0 otherwise.
  - d now holds the LSB-aligned result.
- start while busy=1 is ignored; no queuing.
- Changes on the operand and opcode inputs during RUN have no effect on the result.
- d and e are intermediate during RUN. They are stable from the done cycle until the next accepted start.

## Timing
- Reset (asynchronous assert, any state, including mid-RUN): go to IDLE with busy=0, done=0, d=0, e=0, ovf=0. The counter, shift registers and carry are cleared, and any partial operation is discarded.
- Latency: start is sampled at edge k; busy=1 after edges k..k+WIDTH-1; done=1 for exactly the cycle after edge k+WIDTH.
- Throughput: start asserted during the done cycle is accepted at that edge. Back-to-back operations therefore take one per WIDTH+1 cycles, and done still pulses for the earlier operation.
- No combinational path from any input to any output.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - Port ovf exists and a sign-carry flop is added.
  - On the final RUN bit of an add, ovf = carry_into_MSB ^ carry_out_of_MSB; ovf=0 for other operations.
  - ovf is updated with e and held the same way.
- SERIAL_ALU_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, start with add, a=8'h3C, b=8'h05, cin=1 -> done exactly 8 cycles after the start edge; d=8'h42, e=0; busy high for exactly 8 cycles.
- Add, a=8'hFF, b=8'h01, cin=0 -> d=8'h00, e=1, ovf=0. Add, a=8'h7F, b=8'h01 -> d=8'h80, e=0, ovf=1 (ovf checks only with SERIAL_ALU_OVF_EN).
- a=8'hA5, b=8'h0F: AND -> d=8'h05, e=0; NOR -> d=8'h50, e=0; XOR -> d=8'hAA, e=0, even with cin=1.
- Hold start high and change a/b every cycle during RUN -> result matches the operands from the accepting edge and there is no restart. Assert start in the done cycle -> second operation accepted, done pulses twice, 9 cycles apart.
- Drop rst_n low asynchronously 4 cycles into an add -> busy, done, d, e drop to 0 immediately. After release, a fresh add 8'h10+8'h20 returns d=8'h30.
- Repeat the add and AND cases at WIDTH=2 and WIDTH=32 (e.g. 32'hFFFFFFFF+1 -> d=0, e=1) -> latency equals WIDTH.
